// File: rtl/gb_lcd_pkg.sv
// Shared Game Boy LCD definitions: geometry defaults, pixel type, and the tx FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gb_lcd_pkg;

  localparam int unsigned GB_H_PIX   = 160;
  localparam int unsigned GB_V_LINES = 144;

  typedef logic [1:0] pix_t;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    HSYNC,
    PIXELS,
    HBLANK,
    DONE
  } state_t;

endpackage

// File: rtl/gb_lcd_tx_if.sv
// Game Boy LCD pin bundle between the transmitter (master) and the capture side (slave).
// Latency: n/a (wires only).
// Backpressure: none; the receiver must keep up with lcd_clk.
interface gb_lcd_tx_if;
  import gb_lcd_pkg::*;

  logic lcd_clk;
  logic lcd_hsync;
  logic lcd_vsync;
  pix_t lcd_data;

  modport master (output lcd_clk, lcd_hsync, lcd_vsync, lcd_data);
  modport slave  (input  lcd_clk, lcd_hsync, lcd_vsync, lcd_data);

endinterface

// File: rtl/gb_lcd_phase.sv
// lcd_clk phase divider: rise = period end, fall = mid period, fetch = 2 clks before period end.
// Latency: strobes are combinational from the divider registers.
// Backpressure: none; clr holds the divider at the start of a period.
module gb_lcd_phase #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic rise,
  output logic fall,
  output logic fetch
);

  localparam int CW = $clog2(HALF_PERIOD);

  logic [CW-1:0] cnt;
  logic          phase;
  logic          tick;

  assign tick  = (cnt == CW'(HALF_PERIOD - 1));
  assign rise  = tick & phase;
  assign fall  = tick & ~phase;
  // Two clocks before the period end; needs HALF_PERIOD >= 3 to land in the second half.
  assign fetch = phase & (cnt == CW'(HALF_PERIOD - 3));

  // Count 0..HALF_PERIOD-1 and flip the half-period phase at terminal count.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gb_lcd_tx.sv
// Game Boy LCD transmitter: framebuffer pixels -> lcd_clk/hsync/vsync/data frames.
// Latency: pix_addr leads its lcd_clk rise by 2 clks; pix_data is used 1 clk after pix_addr.
// Backpressure: none; frames run free while enable is high. GB_LCD_TX_PATTERN_EN selects the internal stripe generator.
module gb_lcd_tx
  import gb_lcd_pkg::*;
#(
  parameter int H_PIX        = GB_H_PIX,
  parameter int V_LINES      = GB_V_LINES,
  parameter int HALF_PERIOD  = 4,
  parameter int HSYNC_CLKS   = 2,
  parameter int HBLANK_CLKS  = 40,
  parameter int VSYNC_CLKS   = 4,
  parameter int VBLANK_LINES = 10,
  parameter int ADDR_W       = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] pix_addr,
  input  pix_t              pix_data,
  gb_lcd_tx_if.master       lcd,
  output logic              busy,
  output logic              frame_done
);

  localparam int PCW = 16;
  localparam int LW  = 16;

  state_t         state;
  logic [PCW-1:0] per_cnt;
  logic [PCW-1:0] per_lim;
  logic [LW-1:0]  line;
  logic           rise;
  logic           fall;
  logic           fetch;
  logic           last_per;
  logic           pix_next;
  pix_t           pix;

  gb_lcd_phase #(.HALF_PERIOD(HALF_PERIOD)) u_phase (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == IDLE || state == DONE),
    .rise  (rise),
    .fall  (fall),
    .fetch (fetch)
  );

  // Number of periods spent in the current state, minus one.
  always_comb begin
    per_lim = '0;
    case (state)
      VSYNC:   per_lim = PCW'(VSYNC_CLKS - 1);
      HSYNC:   per_lim = PCW'(HSYNC_CLKS - 1);
      PIXELS:  per_lim = PCW'(H_PIX - 1);
      HBLANK:  per_lim = PCW'(HBLANK_CLKS - 1);
      default: per_lim = '0;
    endcase
  end

  assign last_per = (per_cnt == per_lim);
  // The next period carries a pixel: first one follows HSYNC on a visible line, no rise after the last pixel.
  assign pix_next = (state == HSYNC && last_per && line < LW'(V_LINES)) ||
                    (state == PIXELS && !last_per);

`ifdef GB_LCD_TX_PATTERN_EN
  logic [PCW-1:0] px;
  assign px       = (state == PIXELS) ? per_cnt + 1'b1 : '0;
  assign pix      = pix_t'(px[3:2] + line[3:2]);
  assign pix_addr = '0;
`else
  logic [ADDR_W-1:0] fetch_addr;
  assign pix = pix_data;

  // Issue sequential framebuffer addresses ahead of each pixel rise; restart at every VSYNC.
  always_ff @(posedge clk) begin
    if (!rst_n || state == VSYNC) begin
      pix_addr   <= '0;
      fetch_addr <= '0;
    end else if (fetch && pix_next) begin
      pix_addr   <= fetch_addr;
      fetch_addr <= fetch_addr + 1'b1;
    end
  end
`endif

  // Frame FSM with registered LCD outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      per_cnt       <= '0;
      line          <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      lcd.lcd_clk   <= 1'b0;
      lcd.lcd_hsync <= 1'b1;
      lcd.lcd_vsync <= 1'b0;
      lcd.lcd_data  <= '0;
    end else begin
      frame_done <= 1'b0;

      if (state == PIXELS && fall) lcd.lcd_clk <= 1'b0;
      if (rise && pix_next) begin
        lcd.lcd_clk  <= 1'b1;
        lcd.lcd_data <= ~pix;
      end

      if (rise) per_cnt <= last_per ? '0 : per_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (enable) begin
            state         <= VSYNC;
            busy          <= 1'b1;
            per_cnt       <= '0;
            line          <= '0;
            lcd.lcd_vsync <= 1'b1;
            lcd.lcd_hsync <= 1'b1;
          end
        end
        VSYNC: begin
          if (rise && last_per) begin
            state         <= HSYNC;
            lcd.lcd_vsync <= 1'b0;
          end
        end
        HSYNC: begin
          if (rise && last_per) begin
            state         <= (line < LW'(V_LINES)) ? PIXELS : HBLANK;
            lcd.lcd_hsync <= 1'b0;
          end
        end
        PIXELS: begin
          if (rise && last_per) state <= HBLANK;
        end
        HBLANK: begin
          if (rise && last_per) begin
            line          <= line + 1'b1;
            lcd.lcd_hsync <= 1'b1;
            if (line + 1'b1 == LW'(V_LINES + VBLANK_LINES)) begin
              state      <= DONE;
              frame_done <= 1'b1;
            end else begin
              state <= HSYNC;
            end
          end
        end
        DONE: begin
          per_cnt <= '0;
          line    <= '0;
          if (enable) begin
            state         <= VSYNC;
            lcd.lcd_vsync <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gb_lcd_tx.sv
// Bench for gb_lcd_tx: small frame geometry, synchronous framebuffer model returning addr[1:0].
// Latency: expectations are queued at stimulus time and popped on each lcd_clk rise / frame_done.
// Backpressure: n/a.
module tb_gb_lcd_tx;
  import gb_lcd_pkg::*;

  localparam int H   = 4;
  localparam int V   = 3;
  localparam int VB  = 1;
  localparam int HP  = 4;
  localparam int HS  = 2;
  localparam int HBK = 40;
  localparam int VS  = 4;
  localparam int AW  = 15;
  localparam int PER = 2 * HP;
  localparam int FRAME_CLKS = PER * (VS + V * (HS + H + HBK) + VB * (HS + HBK));

  typedef struct {
    logic [AW-1:0] addr;
    pix_t          data;
  } pix_exp_t;

  typedef struct {
    int clks;
    int rises;
  } frame_exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [AW-1:0] pix_addr;
  pix_t          pix_data = '0;
  logic          busy;
  logic          frame_done;

  pix_exp_t   pq[$];
  frame_exp_t fq[$];
  int tests = 0;
  int fails = 0;

  gb_lcd_tx_if lcd();

  gb_lcd_tx #(
    .H_PIX(H), .V_LINES(V), .HALF_PERIOD(HP), .HSYNC_CLKS(HS),
    .HBLANK_CLKS(HBK), .VSYNC_CLKS(VS), .VBLANK_LINES(VB), .ADDR_W(AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pix_addr   (pix_addr),
    .pix_data   (pix_data),
    .lcd        (lcd),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Synchronous framebuffer: data is addr[1:0], one clock after the address.
  always @(posedge clk) pix_data <= pix_addr[1:0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame();
    pix_exp_t   e;
    frame_exp_t f;
    pix_t       p;
    for (int l = 0; l < V; l++) begin
      for (int x = 0; x < H; x++) begin
`ifdef GB_LCD_TX_PATTERN_EN
        e.addr = '0;
        p = pix_t'((x >> 2) + (l >> 2));
`else
        e.addr = AW'(l * H + x);
        p = e.addr[1:0];
`endif
        e.data = ~p;
        pq.push_back(e);
      end
    end
    f.clks  = FRAME_CLKS;
    f.rises = H * V;
    fq.push_back(f);
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_lcd_clk"}, lcd.lcd_clk, 0);
    check({tag, "_hsync"}, lcd.lcd_hsync, 1);
    check({tag, "_vsync"}, lcd.lcd_vsync, 0);
    check({tag, "_data"}, lcd.lcd_data, 0);
    check({tag, "_pix_addr"}, pix_addr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!frame_done && n < FRAME_CLKS + 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_frame_done_seen"}, frame_done, 1);
    @(negedge clk);
    check({tag, "_busy_after_done"}, busy, 0);
  endtask

  task automatic idle_watch(input string tag, input int clks);
    int act = 0;
    for (int i = 0; i < clks; i++) begin
      @(negedge clk);
      if (lcd.lcd_vsync || busy || lcd.lcd_clk) act++;
    end
    check({tag, "_idle_activity"}, act, 0);
    check({tag, "_pixels_left"}, pq.size(), 0);
  endtask

  // Monitor: compares each lcd_clk rise and frame_done against the queued expectations.
  initial begin : monitor
    logic prev_clk = 1'b0;
    logic prev_busy = 1'b0;
    int hi = 0;
    int rises = 0;
    int cyc = 0;
    logic [AW-1:0] a1 = '0, a2 = '0, a3 = '0;
    pix_exp_t   e;
    frame_exp_t f;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_clk = 1'b0; prev_busy = 1'b0; hi = 0; rises = 0; cyc = 0;
      end else begin
        if (busy && !prev_busy) cyc = 0;
        else cyc++;
        if (lcd.lcd_clk && !prev_clk) begin
          rises++;
          hi = 1;
          check("rise_expected", pq.size() != 0, 1);
          if (pq.size() != 0) begin
            e = pq.pop_front();
            check("lcd_data", lcd.lcd_data, e.data);
            check("addr_rise_minus2", a2, e.addr);
            check("addr_rise_minus1", a1, e.addr);
            if (e.addr != 0) check("addr_rise_minus3", a3, e.addr - 1'b1);
          end
          check("hsync_at_rise", lcd.lcd_hsync, 0);
        end else if (lcd.lcd_clk) begin
          hi++;
        end else if (prev_clk) begin
          check("clk_high_clks", hi, HP);
        end
        if (frame_done) begin
          check("frame_done_expected", fq.size() != 0, 1);
          if (fq.size() != 0) begin
            f = fq.pop_front();
            check("frame_done_cycle", cyc, f.clks);
            check("rises_per_frame", rises, f.rises);
          end
          check("busy_in_done", busy, 1);
          rises = 0;
        end
        prev_clk  = lcd.lcd_clk;
        prev_busy = busy;
      end
      a3 = a2; a2 = a1; a1 = pix_addr;
    end
  end

  initial begin : stimulus
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
    drive_edge();
    rst_n = 1'b1;

    // One frame from a single-clock enable pulse.
    push_frame();
    enable = 1'b1;
    drive_edge();
    enable = 1'b0;
    wait_done("pulse");
    idle_watch("pulse", 100);

    // enable dropped during line 1: frame completes, nothing follows.
    drive_edge();
    push_frame();
    enable = 1'b1;
    n = 0;
    while (pq.size() > H * V - H - 1 && n < FRAME_CLKS) begin
      @(negedge clk);
      n++;
    end
    check("reached_line1", pq.size(), H * V - H - 1);
    drive_edge();
    enable = 1'b0;
    wait_done("drop");
    idle_watch("drop", 200);

    // One-clock reset in PIXELS with enable held: abort, then full VSYNC.
    drive_edge();
    push_frame();
    enable = 1'b1;
    n = 0;
    while (pq.size() == H * V && n < FRAME_CLKS) begin
      @(negedge clk);
      n++;
    end
    check("reached_pixels", pq.size(), H * V - 1);
    drive_edge();
    rst_n = 1'b0;
    drive_edge();
    rst_n = 1'b1;
    pq.delete();
    fq.delete();
    push_frame();
    @(negedge clk);
    check_reset_values("midrst");
    n = 0;
    while (!lcd.lcd_vsync && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (lcd.lcd_vsync && n < 4 * VS * PER) begin
      @(negedge clk);
      n++;
    end
    check("vsync_clks_after_rst", n, VS * PER);
    drive_edge();
    enable = 1'b0;
    wait_done("rerun");
    idle_watch("rerun", 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
